// File: rtl/keccak_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keccak_sponge_ctrl
// Purpose  : Sponge absorb/pad/squeeze controller driving a Keccak-f[1600] core.
// Revision : 1.0
// ============================================================================
module keccak_sponge_ctrl #(
  parameter int         RATE_LANES = 17,
  parameter int         OUT_LANES  = 4,
  parameter logic [7:0] PAD_BYTE   = 8'h06
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [63:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  output logic [63:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          perm_start,
  output logic [1599:0] perm_din,
  input  logic          perm_done,
  input  logic [1599:0] perm_dout,
  output logic          busy
);

  localparam int             OCW          = $clog2(OUT_LANES + 1);
  localparam logic [7:0]     c_RATE_BYTES = 8'(RATE_LANES * 8);
  localparam logic [4:0]     c_LAST_LANE  = 5'(RATE_LANES - 1);
  localparam logic [OCW-1:0] c_OUT_LANES  = OCW'(OUT_LANES);
  localparam logic [OCW-1:0] c_OUT_FINAL  = OCW'(OUT_LANES - 1);

  typedef enum logic [2:0] {
    S_ABSORB  = 3'd0,
    S_PAD     = 3'd1,
    S_PERM_A  = 3'd2,
    S_WAIT_A  = 3'd3,
    S_SQUEEZE = 3'd4,
    S_PERM_S  = 3'd5,
    S_WAIT_S  = 3'd6
  } state_t;

  state_t          r_fsm, w_fsm_nxt;
  logic [1599:0]   r_state, w_state_nxt;
  logic [4:0]      r_idx, w_idx_nxt;
  logic [4:0]      r_sidx, w_sidx_nxt;
  logic [OCW-1:0]  r_ocnt, w_ocnt_nxt;
  logic [7:0]      r_pad_pos, w_pad_pos_nxt;
  logic            r_final, w_final_nxt;
  logic            r_extra, w_extra_nxt;
  logic            r_out_valid, r_out_last, r_perm_start, r_busy;

  logic [3:0]      w_nbytes;
  logic [63:0]     w_mask;
  logic [63:0]     w_lane_data;

  // Bytes at or above the valid count of a final lane never reach the state.
  always_comb begin
    w_nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    w_mask   = '0;
    for (int k = 0; k < 8; k++) begin
      w_mask[8*k +: 8] = (4'(k) < w_nbytes) ? 8'hFF : 8'h00;
    end
    w_lane_data = in_last ? (in_data & w_mask) : in_data;
  end

  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_sidx_nxt    = r_sidx;
    w_ocnt_nxt    = r_ocnt;
    w_pad_pos_nxt = r_pad_pos;
    w_final_nxt   = r_final;
    w_extra_nxt   = r_extra;
    case (r_fsm)
      S_ABSORB: begin
        if (in_valid) begin
          w_state_nxt[64*r_idx +: 64] = r_state[64*r_idx +: 64] ^ w_lane_data;
          if (in_last) begin
            w_pad_pos_nxt = {r_idx, 3'b000} + {4'b0000, w_nbytes};
            w_idx_nxt     = 5'd0;
            w_fsm_nxt     = S_PAD;
          end else if (r_idx == c_LAST_LANE) begin
            w_idx_nxt = 5'd0;
            w_fsm_nxt = S_PERM_A;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end
      S_PAD: begin
        // A message that exactly fills the block needs a whole extra pad block.
        if (r_pad_pos < c_RATE_BYTES) begin
          w_state_nxt[8*r_pad_pos +: 8] = w_state_nxt[8*r_pad_pos +: 8] ^ PAD_BYTE;
          w_state_nxt[8*(RATE_LANES*8-1) +: 8] =
            w_state_nxt[8*(RATE_LANES*8-1) +: 8] ^ 8'h80;
          w_final_nxt = 1'b1;
        end else begin
          w_extra_nxt   = 1'b1;
          w_pad_pos_nxt = 8'd0;
        end
        w_fsm_nxt = S_PERM_A;
      end
      S_PERM_A: w_fsm_nxt = S_WAIT_A;
      S_WAIT_A: begin
        if (perm_done) begin
          w_state_nxt = perm_dout;
          if (r_final) begin
            w_final_nxt = 1'b0;
            w_sidx_nxt  = 5'd0;
            w_ocnt_nxt  = '0;
            w_fsm_nxt   = S_SQUEEZE;
          end else if (r_extra) begin
            w_extra_nxt = 1'b0;
            w_fsm_nxt   = S_PAD;
          end else begin
            w_fsm_nxt = S_ABSORB;
          end
        end
      end
      S_SQUEEZE: begin
        if (r_out_valid && out_ready) begin
          if (r_ocnt + OCW'(1) == c_OUT_LANES) begin
            w_state_nxt = '0;
            w_idx_nxt   = 5'd0;
            w_sidx_nxt  = 5'd0;
            w_ocnt_nxt  = '0;
            w_fsm_nxt   = S_ABSORB;
          end else begin
            w_ocnt_nxt = r_ocnt + OCW'(1);
            if (r_sidx == c_LAST_LANE) begin
              w_sidx_nxt = 5'd0;
              w_fsm_nxt  = S_PERM_S;
            end else begin
              w_sidx_nxt = r_sidx + 5'd1;
            end
          end
        end
      end
      S_PERM_S: w_fsm_nxt = S_WAIT_S;
      S_WAIT_S: begin
        if (perm_done) begin
          w_state_nxt = perm_dout;
          w_fsm_nxt   = S_SQUEEZE;
        end
      end
      default: w_fsm_nxt = S_ABSORB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fsm        <= S_ABSORB;
      r_state      <= '0;
      r_idx        <= 5'd0;
      r_sidx       <= 5'd0;
      r_ocnt       <= '0;
      r_pad_pos    <= 8'd0;
      r_final      <= 1'b0;
      r_extra      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_perm_start <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_nxt;
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_sidx       <= w_sidx_nxt;
      r_ocnt       <= w_ocnt_nxt;
      r_pad_pos    <= w_pad_pos_nxt;
      r_final      <= w_final_nxt;
      r_extra      <= w_extra_nxt;
      r_out_valid  <= (w_fsm_nxt == S_SQUEEZE);
      r_out_last   <= (w_fsm_nxt == S_SQUEEZE) && (w_ocnt_nxt == c_OUT_FINAL);
      r_perm_start <= (w_fsm_nxt == S_PERM_A) || (w_fsm_nxt == S_PERM_S);
      r_busy       <= !((w_fsm_nxt == S_ABSORB) && (w_idx_nxt == 5'd0));
    end
  end

  assign in_ready   = (r_fsm == S_ABSORB);
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign out_data   = r_state[64*r_sidx +: 64];
  assign perm_start = r_perm_start;
  assign perm_din   = r_state;
  assign busy       = r_busy;

endmodule
`default_nettype wire
